// File: rtl/divider_4.sv
// divider_4: free-running divide-by-4 clock-enable source.
// A 2-bit phase counter drives registered divide-by-2, divide-by-4 and
// 90-degree-shifted divide-by-4 waves, a once-per-period tick, a wrapping
// count of completed periods and a sticky lock flag.
// Every output is a flop. Each flop's next value is decoded from the
// next phase rather than the current one, so the output lines up with the
// phase register after the same edge.
module divider_4 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [1:0]       phase,
    output logic             clk_div2,
    output logic             clk_div4,
    output logic             clk_div4_q,
    output logic             tick,
    output logic [CNT_W-1:0] period_cnt,
    output logic             locked
);

    // Declaration initialisers give every flop its reset value at power-up,
    // so outputs are defined even if no reset edge is ever sampled.
    logic [1:0]       phase_q      = 2'd0;
    logic             clk_div2_q   = 1'b0;
    logic             clk_div4_r   = 1'b0;
    logic             clk_div4_q_r = 1'b0;
    logic             tick_q       = 1'b0;
    logic [CNT_W-1:0] period_cnt_q = '0;
    logic             locked_q     = 1'b0;

    logic [1:0]       phase_d;
    logic             clk_div2_d;
    logic             clk_div4_d;
    logic             clk_div4_q_d;
    logic             tick_d;
    logic [CNT_W-1:0] period_cnt_d;
    logic             locked_d;
    logic             wrap;

    // Next-state: advance phase and decode the waves from the new phase.
    always_comb begin
        phase_d      = phase_q;
        clk_div2_d   = 1'b0;
        clk_div4_d   = 1'b0;
        clk_div4_q_d = 1'b0;
        tick_d       = 1'b0;
        period_cnt_d = period_cnt_q;
        locked_d     = locked_q;
        wrap         = (phase_q == 2'd3);

        phase_d      = phase_q + 2'd1;
        clk_div2_d   = phase_d[0];
        clk_div4_d   = phase_d[1];
        // High in phases 1 and 2: leads clk_div4 by one cycle.
        clk_div4_q_d = phase_d[0] ^ phase_d[1];
        tick_d       = (phase_d == 2'd3);

        if (wrap) begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
            locked_d     = 1'b1;
        end
    end

    // State registers; reset takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= 2'd0;
            clk_div2_q   <= 1'b0;
            clk_div4_r   <= 1'b0;
            clk_div4_q_r <= 1'b0;
            tick_q       <= 1'b0;
            period_cnt_q <= '0;
            locked_q     <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            clk_div2_q   <= clk_div2_d;
            clk_div4_r   <= clk_div4_d;
            clk_div4_q_r <= clk_div4_q_d;
            tick_q       <= tick_d;
            period_cnt_q <= period_cnt_d;
            locked_q     <= locked_d;
        end
    end

    assign phase      = phase_q;
    assign clk_div2   = clk_div2_q;
    assign clk_div4   = clk_div4_r;
    assign clk_div4_q = clk_div4_q_r;
    assign tick       = tick_q;
    assign period_cnt = period_cnt_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_divider_4.sv
// tb_divider_4: directed bench for divider_4, default width plus a
// 2-bit period counter instance sharing clock and reset.
module tb_divider_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  phase_a, phase_b;
    logic        div2_a, div4_a, div4q_a, tick_a, locked_a;
    logic        div2_b, div4_b, div4q_b, tick_b, locked_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    divider_4 #(.CNT_W(16)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase_a),
        .clk_div2   (div2_a),
        .clk_div4   (div4_a),
        .clk_div4_q (div4q_a),
        .tick       (tick_a),
        .period_cnt (cnt_a),
        .locked     (locked_a)
    );

    divider_4 #(.CNT_W(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase_b),
        .clk_div2   (div2_b),
        .clk_div4   (div4_b),
        .clk_div4_q (div4q_b),
        .tick       (tick_b),
        .period_cnt (cnt_b),
        .locked     (locked_b)
    );

    // 50 ns period, first rising edge at 25 ns.
    always #25 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] exp_phase [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_div2  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       exp_div4  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_div4q [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_tick  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_cnt_b [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        int tick_cnt   = 0;
        int tick_bad   = 0;
        int div2_high  = 0;
        int div4_high  = 0;
        int lead_bad   = 0;
        int q_rise_at  = -10;
        int q_fall_at  = -10;
        logic prev_tick = 1'b0;
        logic prev_div4 = 1'b0;
        logic prev_q    = 1'b0;

        // Power-up: reset released before the first edge samples it.
        #10;
        check("powerup_outputs", {26'd0, phase_a, div2_a, div4_a, div4q_a, tick_a},
              32'd0);
        check("powerup_cnt_locked", {15'd0, locked_a, cnt_a}, 32'd0);
        #10;
        rst = 1'b0;

        for (int n = 1; n <= 100; n++) begin
            step();
            if (n <= 4) begin
                check($sformatf("pu_phase_e%0d", n), 32'(phase_a), 32'(exp_phase[n-1]));
                check($sformatf("pu_div2_e%0d", n), 32'(div2_a), 32'(exp_div2[n-1]));
                check($sformatf("pu_div4_e%0d", n), 32'(div4_a), 32'(exp_div4[n-1]));
                check($sformatf("pu_div4q_e%0d", n), 32'(div4q_a), 32'(exp_div4q[n-1]));
                check($sformatf("pu_tick_e%0d", n), 32'(tick_a), 32'(exp_tick[n-1]));
            end
            if (n <= 3) check($sformatf("pu_locked_low_e%0d", n), 32'(locked_a), 32'd0);
            if (n == 4) begin
                check("first_wrap_cnt", 32'(cnt_a), 32'd1);
                check("first_wrap_locked", 32'(locked_a), 32'd1);
            end
            if (n % 4 == 0 && n <= 20) begin
                check($sformatf("w2_cnt_e%0d", n), 32'(cnt_b), 32'(exp_cnt_b[n/4-1]));
                check($sformatf("w2_locked_e%0d", n), 32'(locked_b), 32'd1);
            end
            if (n <= 50) begin
                if (tick_a) tick_cnt++;
                if (tick_a && (prev_tick || phase_a != 2'd3)) tick_bad++;
            end
            if (n == 48) begin
                check("e48_cnt", 32'(cnt_a), 32'd12);
                check("e48_locked", 32'(locked_a), 32'd1);
            end
            if (n == 50) begin
                check("e50_tick_count", 32'(tick_cnt), 32'd12);
                check("e50_tick_shape", 32'(tick_bad), 32'd0);
            end
            if (div2_a) div2_high++;
            if (div4_a) div4_high++;
            if (div4q_a && !prev_q) q_rise_at = n;
            if (!div4q_a && prev_q) q_fall_at = n;
            if (div4_a && !prev_div4 && q_rise_at != n - 1) lead_bad++;
            if (!div4_a && prev_div4 && q_fall_at != n - 1) lead_bad++;
            prev_tick = tick_a;
            prev_div4 = div4_a;
            prev_q    = div4q_a;
        end
        check("duty_div2", 32'(div2_high), 32'd50);
        check("duty_div4", 32'(div4_high), 32'd50);
        check("div4q_lead", 32'(lead_bad), 32'd0);
        check("e100_cnt", 32'(cnt_a), 32'd25);

        // Reset held for three edges.
        rst = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            check($sformatf("hold_outputs_e%0d", n),
                  {25'd0, locked_a, phase_a, div2_a, div4_a, div4q_a, tick_a}, 32'd0);
            check($sformatf("hold_cnt_e%0d", n), 32'(cnt_a), 32'd0);
        end
        rst = 1'b0;
        for (int n = 1; n <= 23; n++) begin
            step();
            if (n <= 3) begin
                check($sformatf("rel_phase_e%0d", n), 32'(phase_a), 32'(n));
                check($sformatf("rel_locked_e%0d", n), 32'(locked_a), 32'd0);
            end
        end
        check("pre_rst_phase", 32'(phase_a), 32'd3);
        check("pre_rst_cnt", 32'(cnt_a), 32'd5);
        check("pre_rst_tick", 32'(tick_a), 32'd1);

        // Reset in phase 3 must suppress the increment and the tick.
        rst = 1'b1;
        step();
        check("rst_p3_phase", 32'(phase_a), 32'd0);
        check("rst_p3_cnt", 32'(cnt_a), 32'd0);
        check("rst_p3_tick", 32'(tick_a), 32'd0);
        check("rst_p3_locked", 32'(locked_a), 32'd0);
        check("rst_p3_cnt_b", 32'(cnt_b), 32'd0);
        rst = 1'b0;
        step();
        check("after_rst_phase", 32'(phase_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
